aes_spi_frame_slave: RTL and testbench
======================================

# aes_spi_frame_slave

Command-framed SPI slave that fronts a sequential AES core. It shifts in a command byte, a 128-bit block and an Nk-word key, then runs a start/done handshake with the external core. The result is returned behind a start-bit preamble, so the master can poll through a core latency that is variable and not known in advance. Per-frame encrypt/decrypt selection, a wait timeout and error reporting are added; the engine itself is not instantiated here.

## Interface
Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8.
- WAIT_MAX, 1023, maximum clk cycles spent in WAIT before timeout; legal range 1..65535.

Ports:
- clk  in  1  SPI clock, also the block clock; SDI is sampled on the rising edge and SDO is driven on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- CS  in  1  chip select, active low; sampled on the rising edge of clk.
- SDI  in  1  serial data in, MSB first.
- SDO  out  1  serial data out, MSB first.
- core_start  out  1  one-cycle request pulse to the AES core.
- core_mode  out  1  1 = encrypt, 0 = decrypt.
- core_data  out  128  block presented to the core.
- core_key  out  32*Nk  key presented to the core.
- core_done  in  1  core result valid; single cycle.
- core_result  in  128  core output, qualified by core_done.
- frame_err  out  1  sticky error flag; cleared when the next frame starts.

## Operation
- States: IDLE, CMD, DATA, KEY, START, WAIT, PRE, SHIFT, DONE.
- Reset values: all outputs 0, state IDLE, all registers 0.
- IDLE → CMD on the first rising edge with CS=0. That same edge samples command bit 7 and clears frame_err.
- Command byte, first 8 bits, MSB first:
  - bit7 = mode.
  - bit6 = key_load.
  - bits5:0 reserved and ignored.
- CMD → DATA after 8 bits. DATA shifts 128 bits into the data register, left-shift with the new bit in the LSB.
- DATA → KEY when a key is expected; otherwise DATA → START. KEY shifts 32*Nk bits, same order as DATA. KEY → START after the last key bit.
- START: assert core_start for exactly one cycle, then go to WAIT.
  - core_mode, core_data and core_key are registered.
  - They must stay stable from START until core_done is accepted or the frame is aborted.
- WAIT: a 16-bit counter increments every cycle.
  - core_done=1 → latch core_result into the output shift register, go to PRE.
  - Counter reaches WAIT_MAX with no core_done → set frame_err, go to DONE.
  - While in WAIT, SDO stays 0.
- PRE: SDO=1 for one bit. This is the start bit the master polls for. Then go to SHIFT.
- SHIFT: drive result bits 127..0, one per falling edge, then go to DONE.
- DONE: SDO=0 until CS rises; then go to IDLE.
- CS=1 sampled in any state other than IDLE or DONE (mid-frame abort):
  - set frame_err, go to IDLE;
  - no core_start is issued;
  - data and output registers are cleared;
  - SDO goes to 0 on the next falling edge.
- core_done in any state other than WAIT is ignored, including a late done after an abort or timeout.
- A new frame is accepted only from IDLE. CS must be seen high for at least one rising edge between frames.

## Timing
- Rising edges are numbered k=0.. from the first edge with CS=0.
  - Command bits: k=0..7.
  - Data bits: k=8..135.
  - Key bits, when present: k=136..135+32*Nk.
- core_start is high during the cycle that follows the edge sampling the last input bit.
- On the rising edge where core_done=1 is sampled, the result is latched.
  - The start bit appears on SDO at the next falling edge.
  - Result bit 127 appears one falling edge later; bit 0 appears 128 falling edges after the start bit.
- Minimum frame length: input bits + 1 (START) + 1 (WAIT with immediate done) + 129 output bits.

## Configuration
- AES_SPI_KEY_RETAIN_EN defined:
  - The key register is cleared only by rst.
  - Command bit6=1 loads a new key (KEY phase present).
  - bit6=0 skips KEY and reuses the stored key.
- Not defined:
  - bit6 is ignored and the KEY phase is always present.
  - The key register is cleared at every frame start.

## Test plan
- Nk=4, command 0x80, data 0x00112233445566778899aabbccddeeff, FIPS-197 key 0x000102…0f, core model returns 0x69c4e0d86a7b0430d8cdb78070b4c55a after 5 cycles:
  - core_start pulses once with core_mode=1;
  - SDO shows zeros, then start bit 1, then 0x69c4…c55a MSB first.
- Nk=8, command 0x40 (decrypt) → core_mode=0, core_key holds all 256 bits, and core_start occurs one cycle after edge k=391.
- CS raised at k=50:
  - frame_err=1, no core_start, SDO=0;
  - the next frame with command 0x80 clears frame_err and completes normally.
- Core never asserts done, WAIT_MAX=20:
  - frame_err=1 after 20 WAIT cycles, SDO stays 0;
  - a later stray core_done has no effect.
- With AES_SPI_KEY_RETAIN_EN: frame 1 uses command 0xC0 with a key, frame 2 uses 0x80 with no key bits → frame 2 core_key equals frame 1's key and core_start occurs after k=135.
- rst asserted during SHIFT → SDO, core_start and frame_err all return to 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/aes_spi_frame_slave.sv
// SPI slave framing cmd/data/key into a start/done handshake with an external AES core; result returned behind a start bit.
// AES_SPI_KEY_RETAIN_EN: key kept across frames and KEY phase only when command bit6 is set.

module aes_spi_frame_slave #(
    parameter int Nk       = 4,
    parameter int WAIT_MAX = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CS,
    input  logic              SDI,
    output logic              SDO,
    output logic              core_start,
    output logic              core_mode,
    output logic [127:0]      core_data,
    output logic [32*Nk-1:0]  core_key,
    input  logic              core_done,
    input  logic [127:0]      core_result,
    output logic              frame_err
);

    localparam int          KEY_BITS  = 32 * Nk;
    localparam logic [15:0] KEY_LAST  = 16'(KEY_BITS - 1);
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, DATA, KEY, START, WAIT, PRE, SHIFT, DONE
    } state_t;

    state_t              state, state_nx;
    logic [15:0]         cnt, cnt_nx;
    logic                mode, key_load, err;
    logic [127:0]        data_reg, out_sr;
    logic [KEY_BITS-1:0] key_reg;
    logic                frame_start, abort, timeout, key_phase, accept_done;

    assign frame_start = (state == IDLE) && !CS;
    assign abort       = CS && (state != IDLE) && (state != DONE);
    assign timeout     = (state == WAIT) && !core_done && (cnt == WAIT_LAST);
    assign accept_done = (state == WAIT) && core_done && !abort;

`ifdef AES_SPI_KEY_RETAIN_EN
    assign key_phase = key_load;
`else
    assign key_phase = 1'b1;
`endif

    // cnt restarts from zero on every state change, so each phase counts its own bits/cycles
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!CS) state_nx = CMD;
            CMD:     if (cnt == 16'd6) state_nx = DATA;
            DATA:    if (cnt == 16'd127) state_nx = key_phase ? KEY : START;
            KEY:     if (cnt == KEY_LAST) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (core_done) state_nx = PRE;
                     else if (cnt == WAIT_LAST) state_nx = DONE;
            PRE:     state_nx = SHIFT;
            SHIFT:   if (cnt == 16'd127) state_nx = DONE;
            DONE:    if (CS) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
        cnt_nx = (state_nx != state) ? 16'd0 : cnt + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= 1'b0;
            key_load <= 1'b0;
            err      <= 1'b0;
            data_reg <= '0;
            key_reg  <= '0;
            out_sr   <= '0;
        end else begin
            if (frame_start) begin
                mode     <= SDI;
                key_load <= 1'b0;
                err      <= 1'b0;
`ifndef AES_SPI_KEY_RETAIN_EN
                key_reg  <= '0;
`endif
            end
            if (state == CMD && cnt == 16'd0) key_load <= SDI;
            if (state == DATA) data_reg <= {data_reg[126:0], SDI};
            if (state == KEY)  key_reg  <= {key_reg[KEY_BITS-2:0], SDI};
            if (accept_done)
                out_sr <= core_result;
            else if (state == SHIFT)
                out_sr <= {out_sr[126:0], 1'b0};
            if (timeout) err <= 1'b1;
            if (abort) begin
                err      <= 1'b1;
                data_reg <= '0;
                out_sr   <= '0;
            end
        end
    end

    // SDO launches on the falling edge so the master samples it on the following rising edge
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            SDO <= 1'b0;
        else
            SDO <= (state == PRE) || ((state == SHIFT) && out_sr[127]);
    end

    assign core_start = (state == START);
    assign core_mode  = mode;
    assign core_data  = data_reg;
    assign core_key   = key_reg;
    assign frame_err  = err;

endmodule

// File: tb/tb_aes_spi_frame_slave.sv
// Scoreboard bench: stimulus queues expected core requests and results, monitors pop and compare.
module tb_aes_spi_frame_slave;

    localparam logic [127:0] DATA1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RES1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DATA2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RES2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY8  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] ONES  = {128{1'b1}};
`ifdef AES_SPI_KEY_RETAIN_EN
    localparam logic [7:0]   CMD_ENC = 8'hC0;
`else
    localparam logic [7:0]   CMD_ENC = 8'h80;
`endif

    logic clk = 1'b0, rst = 1'b0, sdi = 1'b0, cs4 = 1'b1, cs8 = 1'b1;
    logic sdo4, start4, mode4, err4, sdo8, start8, mode8, err8;
    logic [127:0] data4, data8, res4 = '0, res8 = '0;
    logic [127:0] key4;
    logic [255:0] key8;
    logic done_m = 1'b0, stray = 1'b0, done4, done8 = 1'b0;
    assign done4 = done_m | stray;

    int checks = 0, errors = 0, cyc = 0, last_s = 0;
    int core_lat = 5;
    bit core_en = 1'b1;
    logic [127:0] core_res = '0;

    typedef struct {
        logic         mode;
        logic [127:0] data;
        logic [255:0] key;
        int           cyc;
    } exp_start_t;
    exp_start_t q4[$], q8[$], e4, e8;
    logic [127:0] qres[$];

    aes_spi_frame_slave #(.Nk(4), .WAIT_MAX(20)) u4 (
        .clk(clk), .rst(rst), .CS(cs4), .SDI(sdi), .SDO(sdo4),
        .core_start(start4), .core_mode(mode4), .core_data(data4), .core_key(key4),
        .core_done(done4), .core_result(res4), .frame_err(err4));

    aes_spi_frame_slave #(.Nk(8), .WAIT_MAX(20)) u8 (
        .clk(clk), .rst(rst), .CS(cs8), .SDI(sdi), .SDO(sdo8),
        .core_start(start8), .core_mode(mode8), .core_data(data8), .core_key(key8),
        .core_done(done8), .core_result(res8), .frame_err(err8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // core requests of the Nk=4 instance
    always @(negedge clk) begin
        if (!rst && start4) begin
            if (q4.size() == 0) chk("start4_unexpected", 256'(start4), 256'(0));
            else begin
                e4 = q4.pop_front();
                chk("start4_mode", 256'(mode4), 256'(e4.mode));
                chk("start4_data", 256'(data4), 256'(e4.data));
                chk("start4_key", 256'(key4), e4.key);
                chk("start4_cycle", 256'(cyc), 256'(e4.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && start8) begin
            if (q8.size() == 0) chk("start8_unexpected", 256'(start8), 256'(0));
            else begin
                e8 = q8.pop_front();
                chk("start8_mode", 256'(mode8), 256'(e8.mode));
                chk("start8_data", 256'(data8), 256'(e8.data));
                chk("start8_key", key8, e8.key);
                chk("start8_cycle", 256'(cyc), 256'(e8.cyc));
            end
        end
    end

    // serial result: a 1 on SDO starts a 128-bit capture
    bit coll = 1'b0;
    int ncol = 0;
    logic [127:0] shreg = '0;
    always @(posedge clk) begin
        if (rst) coll = 1'b0;
        else if (coll) begin
            shreg = {shreg[126:0], sdo4};
            ncol++;
            if (ncol == 128) begin
                coll = 1'b0;
                chk("sdo_result", 256'(shreg), 256'(qres.pop_front()));
            end
        end else if (sdo4) begin
            if (qres.size() == 0) chk("sdo_unexpected_start_bit", 256'(sdo4), 256'(0));
            else begin
                coll = 1'b1;
                ncol = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && start4 && core_en) begin
            repeat (core_lat) @(negedge clk);
            res4   = core_res;
            done_m = 1'b1;
            @(negedge clk);
            done_m = 1'b0;
        end
    end

    task automatic send(input bit sel8, input logic [391:0] v, input int n, input int nsend,
                        input bit push, input logic m, input logic [127:0] d, input logic [255:0] k);
        exp_start_t e;
        for (int i = 0; i < nsend; i++) begin
            @(negedge clk);
            if (i == 0) begin
                last_s = cyc + n;
                if (push) begin
                    e.mode = m; e.data = d; e.key = k; e.cyc = cyc + n;
                    if (sel8) q8.push_back(e); else q4.push_back(e);
                end
            end
            if (sel8) cs8 = 1'b0; else cs4 = 1'b0;
            sdi = v[n-1-i];
        end
        @(negedge clk);
        sdi = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        int t;
        t = 0;
        while (qres.size() != 0 && t < 800) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_result_seen"}, 256'(qres.size()), 256'(0));
        @(negedge clk);
        cs4 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_sdo", 256'(sdo4), 256'(0));
        chk("rst_start", 256'(start4), 256'(0));
        chk("rst_err", 256'(err4), 256'(0));
        chk("rst_mode", 256'(mode4), 256'(0));
        chk("rst_data", 256'(data4), 256'(0));
        chk("rst_key", 256'(key4), 256'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 encrypt frame
        core_res = RES1;
        qres.push_back(RES1);
        send(1'b0, 392'({CMD_ENC, DATA1, KEY1}), 264, 264, 1'b1, 1'b1, DATA1, 256'(KEY1));
        finish_frame("fips_enc");
        chk("fips_enc_err", 256'(err4), 256'(0));

        // Nk=8 decrypt, core never answers
        send(1'b1, 392'({8'h40, DATA1, KEY8}), 392, 392, 1'b1, 1'b0, DATA1, KEY8);
        repeat (25) @(negedge clk);
        chk("nk8_start_seen", 256'(q8.size()), 256'(0));
        chk("nk8_timeout_err", 256'(err8), 256'(1));
        chk("nk8_sdo", 256'(sdo8), 256'(0));
        cs8 = 1'b1;
        repeat (2) @(negedge clk);

        // abort at k=50
        send(1'b0, 392'({CMD_ENC, DATA1, KEY1}), 264, 50, 1'b0, 1'b0, '0, '0);
        cs4 = 1'b1;
        @(negedge clk);
        chk("abort_err", 256'(err4), 256'(1));
        chk("abort_data_cleared", 256'(data4), 256'(0));
        @(negedge clk);
        chk("abort_sdo", 256'(sdo4), 256'(0));
        repeat (3) @(negedge clk);
        core_res = RES2;
        qres.push_back(RES2);
        send(1'b0, 392'({CMD_ENC, DATA2, KEY2}), 264, 264, 1'b1, 1'b1, DATA2, 256'(KEY2));
        chk("after_abort_err_cleared", 256'(err4), 256'(0));
        finish_frame("after_abort");

        // wait timeout, then a stray done
        core_en = 1'b0;
        send(1'b0, 392'({CMD_ENC, DATA1, KEY1}), 264, 264, 1'b1, 1'b1, DATA1, 256'(KEY1));
        chk("to_start_cycle_ref", 256'(cyc), 256'(last_s));
        repeat (20) @(negedge clk);
        chk("to_err_before", 256'(err4), 256'(0));
        @(negedge clk);
        chk("to_err_after", 256'(err4), 256'(1));
        chk("to_sdo", 256'(sdo4), 256'(0));
        core_en = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_err", 256'(err4), 256'(1));
        chk("stray_sdo", 256'(sdo4), 256'(0));
        cs4 = 1'b1;
        repeat (3) @(negedge clk);

`ifdef AES_SPI_KEY_RETAIN_EN
        core_res = RES2;
        qres.push_back(RES2);
        send(1'b0, 392'({8'hC0, DATA2, KEY2}), 264, 264, 1'b1, 1'b1, DATA2, 256'(KEY2));
        finish_frame("retain_load");
        core_res = RES1;
        qres.push_back(RES1);
        send(1'b0, 392'({8'h80, DATA1}), 136, 136, 1'b1, 1'b1, DATA1, 256'(KEY2));
        finish_frame("retain_reuse");
`else
        core_res = RES2;
        qres.push_back(RES2);
        send(1'b0, 392'({8'h00, DATA2, KEY1}), 264, 264, 1'b1, 1'b0, DATA2, 256'(KEY1));
        finish_frame("bit6_ignored");
`endif

        // reset in the middle of an all-ones result
        core_res = ONES;
        qres.push_back(ONES);
        send(1'b0, 392'({CMD_ENC, DATA1, KEY1}), 264, 264, 1'b1, 1'b1, DATA1, 256'(KEY1));
        repeat (40) @(negedge clk);
        chk("shift_sdo_high", 256'(sdo4), 256'(1));
        rst = 1'b1;
        #1;
        chk("rst_shift_sdo", 256'(sdo4), 256'(0));
        chk("rst_shift_start", 256'(start4), 256'(0));
        chk("rst_shift_err", 256'(err4), 256'(0));
        chk("rst_shift_data", 256'(data4), 256'(0));
        @(negedge clk);
        qres.delete();
        cs4 = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        core_res = RES1;
        qres.push_back(RES1);
        send(1'b0, 392'({CMD_ENC, DATA1, KEY1}), 264, 264, 1'b1, 1'b1, DATA1, 256'(KEY1));
        finish_frame("post_reset");

        chk("queues_drained", 256'(q4.size() + q8.size() + qres.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
